// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: takes a, b, cin over a valid/ready handshake, drives an
// external 1-bit full adder one bit pair per clock (LSB first), and returns
// {cout, result} = a + b + cin over a second valid/ready handshake.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/a/b/cin (operand side);
//   fa_s1/fa_s0/fa_cin -> full adder, fa_sum/fa_cout <- full adder;
//   out_valid/out_ready/result/cout (result side); busy (RUN or DONE);
//   ovf (signed overflow) only when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_s1,
  output logic             fa_s0,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             last;

  assign last   = (cnt == LAST);
  assign result = result_q;
  assign cout   = cout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    fa_s1     = 1'b0;
    fa_s0     = 1'b0;
    fa_cin    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        fa_s1  = a_sh[0];
        fa_s0  = b_sh[0];
        fa_cin = carry_q;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_sh     <= a;
        b_sh     <= b;
        carry_q  <= cin;
        cnt      <= '0;
        result_q <= '0;
      end
      if (state == RUN) begin
        // sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
        result_q <= {fa_sum, result_q[WIDTH-1:1]};
        carry_q  <= fa_cout;
        a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
        cnt      <= cnt + 1'b1;
        if (last) cout_q <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  assign ovf = ovf_q;

  // carry_q holds the carry into the MSB on the final RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_q <= carry_q ^ fa_cout;
    end else if (state == DONE && out_ready) begin
      ovf_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: external full adder model, arithmetic reference
// model checked every cycle, plus directed vectors with literal expectations.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         fa_s1;
  logic         fa_s0;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .fa_s1     (fa_s1),
    .fa_s0     (fa_s0),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // external full adder cell
  always_comb {fa_cout, fa_sum} = 2'(fa_s1) + 2'(fa_s0) + 2'(fa_cin);

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string n, input logic [31:0] g,
                     input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, g, e, $time);
    end
  endtask

  // reference model: one operation in flight, tracked by edges since accept
  bit       pend = 1'b0;
  int       age = 0;
  int       ma = 0;
  int       mb = 0;
  int       mc = 0;
  int       cyc = 0;
  int       hs_cnt = 0;
  int       out_cnt = 0;
  int       in_cyc = 0;
  int       out_cyc = 0;
  logic [W:0] got[$];

  function automatic int carry_into(input int i);
    int m;
    m = (1 << i) - 1;
    return (((ma & m) + (mb & m) + mc) >> i) & 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (pend) begin
      if (age >= W) begin
        if (out_ready) begin
          got.push_back({cout, result});
          out_cnt++;
          out_cyc = cyc;
          pend = 1'b0;
        end
      end else begin
        age++;
      end
    end else if (in_valid) begin
      pend = 1'b1;
      age = 0;
      ma = int'(a);
      mb = int'(b);
      mc = int'(cin);
      hs_cnt++;
      in_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int s;
      bit done;
      s = ma + mb + mc;
      done = pend && age >= W;
      chk("in_ready", in_ready, !pend);
      chk("busy", busy, pend);
      chk("out_valid", out_valid, done);
      if (pend && age < W) begin
        chk("fa_s1", fa_s1, (ma >> age) & 1);
        chk("fa_s0", fa_s0, (mb >> age) & 1);
        chk("fa_cin", fa_cin, carry_into(age));
      end else if (!pend) begin
        chk("fa_idle", {fa_s1, fa_s0, fa_cin}, 0);
      end
      if (done) begin
        chk("result", result, s & 'hFF);
        chk("cout", cout, (s >> W) & 1);
      end
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", ovf, done ? (carry_into(W - 1) ^ ((s >> W) & 1)) : 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc);
    int n0;
    n0 = hs_cnt;
    a = xa;
    b = xb;
    cin = xc;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && hs_cnt == n0; i++) step();
    in_valid = 1'b0;
    chk("in_hs", hs_cnt - n0, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
      step();
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int h0;
    int o0;
    int gi;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);

    // 0x0F + 0x01: latency of exactly 8 edges
    send(8'h0F, 8'h01, 1'b0);
    wait_valid(n);
    chk("t1_latency", n, 8);
    chk("t1_result", result, 'h10);
    chk("t1_cout", cout, 0);
    step();
    chk("t1_got", got[got.size()-1], 9'h010);

    // 0xFF + 0x01: carry ripples through every bit
    send(8'hFF, 8'h01, 1'b0);
    for (int k = 0; k < W; k++) begin
      if (k >= 1) chk("t2_fa_cin", fa_cin, 1);
      step();
    end
    chk("t2_result", result, 'h00);
    chk("t2_cout", cout, 1);
    step();
    chk("t2_got", got[got.size()-1], 9'h100);

    // 0xFF + 0xFF + 1 with downstream stalled
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 1'b1);
    wait_valid(n);
    h0 = hs_cnt;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = 8'h01;
      b = 8'h02;
      step();
      chk("t3_out_valid", out_valid, 1);
      chk("t3_result", result, 'hFF);
      chk("t3_cout", cout, 1);
      chk("t3_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t3_idle", in_ready, 1);
    chk("t3_ignored", hs_cnt, h0);
    chk("t3_got", got[got.size()-1], 9'h1FF);

    // reset during RUN cycle 4
    o0 = out_cnt;
    send(8'hAA, 8'h55, 1'b0);
    repeat (4) step();
    chk("t4_busy_pre", busy, 1);
    rst_n = 1'b0;
    step();
    chk("t4_busy", busy, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_out_valid", out_valid, 0);
    rst_n = 1'b1;
    repeat (12) step();
    chk("t4_no_out", out_cnt, o0);
    chk("t4_in_ready2", in_ready, 1);

    // back-to-back with in_valid held high
    gi = got.size();
    o0 = out_cnt;
    h0 = hs_cnt;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && hs_cnt == h0; i++) step();
    a = 8'h80;
    b = 8'h80;
    for (int i = 0; i < 40 && hs_cnt == h0 + 1; i++) step();
    in_valid = 1'b0;
    chk("t5_hs", hs_cnt - h0, 2);
    chk("t5_gap", in_cyc - out_cyc, 1);
    for (int i = 0; i < 40 && out_cnt < o0 + 2; i++) step();
    chk("t5_outs", out_cnt - o0, 2);
    if (got.size() >= gi + 2) begin
      chk("t5_first", got[gi], 9'h046);
      chk("t5_second", got[gi+1], 9'h100);
    end

`ifdef SERIAL_ADD_OVF_EN
    send(8'h7F, 8'h01, 1'b0);
    wait_valid(n);
    chk("t6_result", result, 'h80);
    chk("t6_cout", cout, 0);
    chk("t6_ovf", ovf, 1);
    step();
    chk("t6_ovf_clr", ovf, 0);
    send(8'hFF, 8'h01, 1'b0);
    wait_valid(n);
    chk("t6b_ovf", ovf, 0);
    chk("t6b_cout", cout, 1);
    step();
`endif

    repeat (3) step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
